// File: rtl/sm_accumulator_if.sv
// Operand/result handshake bundle for sm_accumulator; slave = accumulator, master = producer/consumer side.
interface sm_accumulator_if #(
  parameter int N       = 8,
  parameter int MAX_OPS = 16
);
  localparam int CW = $clog2(MAX_OPS + 1);

  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [N-1:0]  in_mag;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [N-1:0]  out_mag;
  logic          out_ovf;
  logic [CW-1:0] out_count;
  logic          busy;

  modport slave (
    input  in_valid, in_sign, in_mag, in_last, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_ovf, out_count, busy
  );

  modport master (
    output in_valid, in_sign, in_mag, in_last, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_ovf, out_count, busy
  );
endinterface

// File: rtl/sm_accumulator.sv
// Streaming sign-magnitude burst accumulator; result valid 1 cycle after closing operand, held until out_ready.
// SM_ACC_SATURATE_EN defined: overflowing adds clamp to 2^N-1; undefined: magnitude wraps.
module sm_accumulator #(
  parameter int N       = 8,
  parameter int MAX_OPS = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  sm_accumulator_if.slave bus
);
  localparam int CW = $clog2(MAX_OPS + 1);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t        r_state;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_sign;
  logic [N-1:0]  r_mag;
  logic          r_ovf;
  logic [CW-1:0] r_count;

  logic          w_accept;
  logic          w_op_sign;
  logic [N:0]    w_sum;
  logic          w_ovf_add;
  logic [N-1:0]  w_add_mag;
  logic          w_add_sign;
  logic          w_res_sign;
  logic [CW-1:0] w_count_nxt;
  logic          w_close;

  assign w_accept    = bus.in_valid && r_in_ready;
  // A -0 operand is folded to +0 before it touches the sum.
  assign w_op_sign   = bus.in_sign && (bus.in_mag != '0);
  assign w_sum       = {1'b0, r_mag} + {1'b0, bus.in_mag};
  assign w_ovf_add   = (r_sign == w_op_sign) && w_sum[N];
  assign w_count_nxt = r_count + CW'(1);
  assign w_close     = bus.in_last || (w_count_nxt == CW'(MAX_OPS));

  always_comb begin
    w_add_mag  = w_sum[N-1:0];
    w_add_sign = r_sign;
    if (r_sign == w_op_sign) begin
`ifdef SM_ACC_SATURATE_EN
      if (w_sum[N]) w_add_mag = '1;
`endif
    end else if (r_mag > bus.in_mag) begin
      w_add_mag = r_mag - bus.in_mag;
    end else begin
      w_add_mag  = bus.in_mag - r_mag;
      w_add_sign = w_op_sign;
    end
    // Zero results (cancellation or wrap) are always +0.
    w_res_sign = w_add_sign && (w_add_mag != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
      r_mag       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          if (w_accept) begin
            r_sign  <= w_op_sign;
            r_mag   <= bus.in_mag;
            r_count <= CW'(1);
            r_ovf   <= 1'b0;
            if (bus.in_last || (MAX_OPS == 1)) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACC;
            end
          end
        end
        ACC: begin
          if (w_accept) begin
            r_sign  <= w_res_sign;
            r_mag   <= w_add_mag;
            r_count <= w_count_nxt;
            r_ovf   <= r_ovf | w_ovf_add;
            if (w_close) begin
              r_state     <= DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sign  = r_sign;
  assign bus.out_mag   = r_mag;
  assign bus.out_ovf   = r_ovf;
  assign bus.out_count = r_count;
  assign bus.busy      = (r_state == ACC);
endmodule

// File: tb/tb_sm_accumulator.sv
// Scoreboard bench for sm_accumulator at N=4, MAX_OPS=4 (works with or without SM_ACC_SATURATE_EN).
module tb_sm_accumulator;
  localparam int N       = 4;
  localparam int MAX_OPS = 4;

  typedef struct packed {
    logic       s;
    logic [3:0] m;
    logic       o;
    logic [2:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  sm_accumulator_if #(.N(N), .MAX_OPS(MAX_OPS)) bus ();

  sm_accumulator #(.N(N), .MAX_OPS(MAX_OPS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic s, input logic [3:0] m, input logic o, input logic [2:0] c);
    exp_t e;
    e.s = s; e.m = m; e.o = o; e.c = c;
    q.push_back(e);
  endtask

  // Offer one operand and hold it until the DUT accepts it.
  task automatic send(input logic s, input logic [3:0] m, input logic l);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_sign  = s;
    bus.in_mag   = m;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Monitor: every result transfer is matched against the next expected entry.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sign=%0d mag=%0d expected no result",
                 bus.out_sign, bus.out_mag);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_sign",  32'(bus.out_sign),  32'(e.s));
        chk("res_mag",   32'(bus.out_mag),   32'(e.m));
        chk("res_ovf",   32'(bus.out_ovf),   32'(e.o));
        chk("res_count", 32'(bus.out_count), 32'(e.c));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_mag    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_sign",  32'(bus.out_sign),  0);
    chk("rst_out_mag",   32'(bus.out_mag),   0);
    chk("rst_out_ovf",   32'(bus.out_ovf),   0);
    chk("rst_out_count", 32'(bus.out_count), 0);
    chk("rst_busy",      32'(bus.busy),      0);
    reset_n = 1'b1;
    bus.out_ready = 1'b1;

    // +5 + +3 = +8, result valid right after the closing accept
    push(1'b0, 4'd8, 1'b0, 3'd2);
    send(1'b0, 4'd5, 1'b0);
    chk("busy_in_acc", 32'(bus.busy), 1);
    send(1'b0, 4'd3, 1'b1);
    chk("latency_valid", 32'(bus.out_valid), 1);

    // +3 + -5 = -2 ; -6 + +6 = +0 ; -0 alone = +0
    push(1'b1, 4'd2, 1'b0, 3'd2);
    send(1'b0, 4'd3, 1'b0);
    send(1'b1, 4'd5, 1'b1);
    push(1'b0, 4'd0, 1'b0, 3'd2);
    send(1'b1, 4'd6, 1'b0);
    send(1'b0, 4'd6, 1'b1);
    push(1'b0, 4'd0, 1'b0, 3'd1);
    send(1'b1, 4'd0, 1'b1);

    // Overflow: +9 + +9 and -8 + -8
`ifdef SM_ACC_SATURATE_EN
    push(1'b0, 4'd15, 1'b1, 3'd2);
`else
    push(1'b0, 4'd2, 1'b1, 3'd2);
`endif
    send(1'b0, 4'd9, 1'b0);
    send(1'b0, 4'd9, 1'b1);
`ifdef SM_ACC_SATURATE_EN
    push(1'b1, 4'd15, 1'b1, 3'd2);
`else
    push(1'b0, 4'd0, 1'b1, 3'd2);
`endif
    send(1'b1, 4'd8, 1'b0);
    send(1'b1, 4'd8, 1'b1);

    // Auto-close at MAX_OPS with the consumer stalled
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    push(1'b0, 4'd4, 1'b0, 3'd4);
    for (int i = 0; i < 4; i++) send(1'b0, 4'd1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_sign  = 1'b0;
    bus.in_mag   = 4'd2;
    bus.in_last  = 1'b1;
    push(1'b0, 4'd2, 1'b0, 3'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_in_ready",  32'(bus.in_ready),  0);
      chk("hold_out_valid", 32'(bus.out_valid), 1);
      chk("hold_out_mag",   32'(bus.out_mag),   4);
      chk("hold_out_count", 32'(bus.out_count), 4);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("idle_in_ready", 32'(bus.in_ready), 1);
    chk("idle_no_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("next_accept_valid", 32'(bus.out_valid), 1);
    chk("next_accept_count", 32'(bus.out_count), 1);
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-burst discards the partial sum
    send(1'b0, 4'd3, 1'b0);
    send(1'b0, 4'd2, 1'b0);
    chk("pre_rst_busy", 32'(bus.busy), 1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy",      32'(bus.busy),      0);
    chk("mid_rst_out_mag",   32'(bus.out_mag),   0);
    chk("mid_rst_out_count", 32'(bus.out_count), 0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  0);
    reset_n = 1'b1;
    push(1'b0, 4'd7, 1'b0, 3'd1);
    send(1'b0, 4'd7, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sm_accumulator.md
# sm_accumulator

Streaming sign-magnitude accumulator, the parametrised successor of the team's combinational sign-magnitude adder. It accepts a burst of N-bit sign-magnitude operands over a valid/ready handshake and sums them into a running sign-magnitude total. It presents the total, the operand count and an overflow flag on a held output handshake. It sits between operand producers and downstream sign-magnitude consumers in the datapath.

## Interface
Parameters:
- N, 8, magnitude width of operands and result
- MAX_OPS, 16, maximum operands per burst (≥1); burst auto-closes on reaching it
- CW, $clog2(MAX_OPS+1), count width (derived localparam, not overridable)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  block accepts operand this cycle
- in_sign  input  1  operand sign, 1 = negative
- in_mag  input  N  operand magnitude
- in_last  input  1  operand is the final one of the burst
- out_valid  output  1  result held valid
- out_ready  input  1  consumer takes result
- out_sign  output  1  result sign
- out_mag  output  N  result magnitude
- out_ovf  output  1  sticky overflow occurred during burst
- out_count  output  CW  operands accumulated in burst
- busy  output  1  burst in progress (state ACC)

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: in_ready=1. On accept: acc ← operand (normalised), count ← 1, ovf ← 0. Go to DONE if in_last or MAX_OPS==1, else ACC.
- ACC: in_ready=1. On accept: acc ← acc ⊕ operand, count+1. Go to DONE if in_last or count+1==MAX_OPS.
- DONE: in_ready=0, out_valid=1, outputs stable. On out_ready go to IDLE.
- Sign-magnitude add ⊕:
  - Equal signs: magnitude = acc_mag + in_mag computed at N+1 bits, with the sign kept. A carry out sets ovf (sticky).
  - Differing signs: magnitude = larger − smaller, and the sign is that of the larger magnitude.
  - Equal magnitudes: result is +0 (sign 0), never −0.
- A −0 operand is treated as +0. out_sign is never 1 when out_mag==0.
- Overflow magnitude: see Configuration.

## Timing
- Reset values: state IDLE, in_ready=0 during reset cycle then 1, out_valid=0, out_sign=0, out_mag=0, out_ovf=0, out_count=0, busy=0.
- Throughput: one operand per cycle while in IDLE/ACC. No combinational path from in_* to out_*.
- Latency: out_valid asserts the cycle after the closing operand is accepted.
- Operand transfer when in_valid&&in_ready. Result transfer when out_valid&&out_ready.
- Backpressure: in DONE, outputs hold indefinitely until out_ready. Operands offered meanwhile are not accepted.
- No same-cycle bypass: after the result transfers, the next operand is accepted in IDLE the following cycle at the earliest.
- in_last and MAX_OPS reached on the same operand: a single closing event with count=MAX_OPS.
- in_last ignored unless in_valid&&in_ready.
- Reset asserted mid-burst or in DONE: partial sum discarded, all outputs return to reset values next edge.

## Configuration
- Macro SM_ACC_SATURATE_EN.
  - Defined: when an add overflows, the magnitude clamps to 2^N−1 with the sign kept. Subsequent ops operate on the clamped value.
  - Undefined: the magnitude wraps to the low N bits of the N+1-bit sum.
- out_ovf behaves identically in both builds.

## Test plan
- N=4: +5, +3(last) -> out_sign=0, out_mag=8, out_count=2, out_ovf=0, out_valid one cycle after last accept.
- N=4: +3, −5(last) -> −2. Then −6, +6(last) -> +0 (sign 0). Then −0 alone(last) -> +0.
- N=4: +9, +9(last) -> wrap build: out_mag=2, out_ovf=1. Saturate build: out_mag=15, out_ovf=1.
- MAX_OPS=4, four +1 operands without in_last, continuous valid -> DONE after 4th, mag=4, count=4. The 5th operand stalls (in_ready=0) until out_ready.
- Hold out_ready=0 for 10 cycles in DONE -> outputs constant, in_ready=0. Pulse out_ready -> IDLE, and the next operand is accepted the following cycle.
- Assert reset_n=0 after two operands in ACC -> next edge: IDLE, all outputs zero. A new burst of +7(last) -> +7, count=1.
